// File: rtl/keypad_scan_pkg.sv
// Shared constants for the 3x3 keypad scanner and its downstream game controller.
// Key index i = row*GRID_DIM + col matches map[i] in the controller.
package keypad_scan_pkg;

    localparam logic [3:0] NO_KEY   = 4'd15;
    localparam int         NUM_KEYS = 9;
    localparam int         GRID_DIM = 3;

    function automatic int idx(input int r, input int c);
        return r * GRID_DIM + c;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Per-key debouncer: the state flips only after DEBOUNCE_SCANS consecutive
// disagreeing samples; rise_o flags the 0->1 flip in the cycle it is registered.
module key_debounce #(
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic sample_en_i,
    input  logic sample_i,
    output logic state_o,
    output logic rise_o
);

    localparam int            CW       = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_SCANS - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          state_q, state_d;

    always_comb begin
        cnt_d   = cnt_q;
        state_d = state_q;
        if (sample_en_i) begin
            if (sample_i == state_q) begin
                cnt_d = '0;
            end else if (cnt_q == CNT_LAST) begin
                // This sample is the DEBOUNCE_SCANS-th disagreement.
                cnt_d   = '0;
                state_d = ~state_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            state_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            state_q <= state_d;
        end
    end

    assign state_o = state_q;
    assign rise_o  = state_d & ~state_q;

endmodule

// File: rtl/keypad_scan.sv
// 3x3 active-low keypad scanner: column sequencing, row synchroniser, per-key
// debounce and a lowest-index-first arbiter producing one-cycle press pulses.
module keypad_scan
    import keypad_scan_pkg::*;
#(
    parameter int SCAN_DIV       = 100_000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [2:0]          row_n,
    output logic [2:0]          col_n,
    output logic [3:0]          one_pulse_pos,
    output logic [NUM_KEYS-1:0] key_down
);

    localparam int            DW       = $clog2(SCAN_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);

    logic [DW-1:0]       div_q, div_d;
    logic [1:0]          col_q, col_d;
    logic [2:0]          sync1_q, sync2_q;
    logic [2:0]          row_s;
    logic                sample_cycle;
    logic [NUM_KEYS-1:0] rise;
    logic [NUM_KEYS-1:0] clear;
    logic [NUM_KEYS-1:0] pending_q, pending_d;
    logic [3:0]          pulse_q, pulse_d;

    // Sampling at the slot end gives the driven column SCAN_DIV-1 cycles to settle.
    assign sample_cycle = (div_q == DIV_LAST);
    assign row_s        = ~sync2_q;

    always_comb begin
        div_d = div_q + 1'b1;
        col_d = col_q;
        if (sample_cycle) begin
            div_d = '0;
            col_d = (col_q == 2'd2) ? 2'd0 : col_q + 2'd1;
        end
    end

    always_comb begin
        case (col_q)
            2'd0:    col_n = 3'b110;
            2'd1:    col_n = 3'b101;
            default: col_n = 3'b011;
        endcase
    end

    for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_key
        localparam int R = gi / GRID_DIM;
        localparam int C = gi % GRID_DIM;
        localparam int K = idx(R, C);

        key_debounce #(
            .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
        ) u_debounce (
            .clk         (clk),
            .rst         (rst),
            .sample_en_i (sample_cycle && (col_q == 2'(C))),
            .sample_i    (row_s[R]),
            .state_o     (key_down[K]),
            .rise_o      (rise[K])
        );
    end

    // Descending scan so the lowest pending index is the one left selected.
    always_comb begin
        clear   = '0;
        pulse_d = NO_KEY;
        for (int k = NUM_KEYS - 1; k >= 0; k--) begin
            if (pending_q[k]) begin
                clear    = '0;
                clear[k] = 1'b1;
                pulse_d  = 4'(k);
            end
        end
        pending_d = (pending_q & ~clear) | rise;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q     <= '0;
            col_q     <= 2'd0;
            sync1_q   <= 3'b111;
            sync2_q   <= 3'b111;
            pending_q <= '0;
            pulse_q   <= NO_KEY;
        end else begin
            div_q     <= div_d;
            col_q     <= col_d;
            sync1_q   <= row_n;
            sync2_q   <= sync1_q;
            pending_q <= pending_d;
            pulse_q   <= pulse_d;
        end
    end

    assign one_pulse_pos = pulse_q;

endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan with a modelled 3x3 switch matrix driven from
// the DUT's column outputs; SCAN_DIV=4, DEBOUNCE_SCANS=3.
module tb_keypad_scan;

    localparam int SD = 4;
    localparam int DS = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] row_n;
    logic [2:0] col_n;
    logic [3:0] one_pulse_pos;
    logic [8:0] key_down;
    logic [8:0] pressed;

    int n_checks = 0;
    int n_pass   = 0;
    int pulse_log[$];

    keypad_scan #(
        .SCAN_DIV       (SD),
        .DEBOUNCE_SCANS (DS)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .row_n         (row_n),
        .col_n         (col_n),
        .one_pulse_pos (one_pulse_pos),
        .key_down      (key_down)
    );

    always #5 clk = ~clk;

    // Switch matrix: a pressed key shorts its row to its column when that column is driven low.
    always_comb begin
        row_n = 3'b111;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                if (pressed[r*3+c] && col_n[c] === 1'b0) row_n[r] = 1'b0;
    end

    always @(negedge clk) begin
        if (one_pulse_pos !== 4'd15) pulse_log.push_back(int'(one_pulse_pos));
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        else n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns just after the edge that ends column c's slot (its sample edge).
    task automatic wait_col_sample(input int c);
        logic [2:0] pat;
        logic [2:0] pre;
        bit         ok;
        pat = ~(3'b001 << c);
        ok  = 0;
        for (int i = 0; i < 40 && !ok; i++) begin
            pre = col_n;
            tick();
            if (pre == pat && col_n != pat) ok = 1;
        end
        if (!ok) begin
            n_checks++;
            $display("FAIL wait_col_sample: column %0d sample edge not seen, col_n=%b", c, col_n);
        end
    endtask

    task automatic test_reset();
        logic [2:0] exp_col;
        rst     = 1'b1;
        pressed = '0;
        repeat (2) tick();
        chk("reset_col_n", 16'(col_n), 16'(3'b110));
        chk("reset_pulse", 16'(one_pulse_pos), 16'd15);
        chk("reset_key_down", 16'(key_down), 16'd0);
        rst = 1'b0;
        pulse_log.delete();
        for (int n = 1; n <= 12; n++) begin
            tick();
            case ((n / SD) % 3)
                0:       exp_col = 3'b110;
                1:       exp_col = 3'b101;
                default: exp_col = 3'b011;
            endcase
            $display("reset scan cycle %0d: col_n=%b expected %b", n, col_n, exp_col);
            chk("scan_col_n", 16'(col_n), 16'(exp_col));
        end
        chk("idle_no_pulse", 16'(pulse_log.size()), 16'd0);
        chk("idle_key_down", 16'(key_down), 16'd0);
    endtask

    task automatic test_hold_key5();
        wait_col_sample(2);
        pressed[5] = 1'b1;
        pulse_log.delete();
        wait_col_sample(2);
        chk("k5_sample1", 16'(key_down[5]), 16'd0);
        wait_col_sample(2);
        chk("k5_sample2", 16'(key_down[5]), 16'd0);
        wait_col_sample(2);
        chk("k5_sample3_set", 16'(key_down), 16'h020);
        chk("k5_no_pulse_yet", 16'(one_pulse_pos), 16'd15);
        tick();
        chk("k5_pulse", 16'(one_pulse_pos), 16'd5);
        tick();
        chk("k5_pulse_end", 16'(one_pulse_pos), 16'd15);
        repeat (2) wait_col_sample(2);
        chk("k5_single_pulse", 16'(pulse_log.size()), 16'd1);
        pressed[5] = 1'b0;
        repeat (2) wait_col_sample(2);
        chk("k5_release_hold", 16'(key_down[5]), 16'd1);
        wait_col_sample(2);
        chk("k5_released", 16'(key_down[5]), 16'd0);
        chk("k5_release_no_pulse", 16'(pulse_log.size()), 16'd1);
        $display("hold key5: pulses seen=%0d", pulse_log.size());
    endtask

    task automatic test_glitch();
        wait_col_sample(0);
        pressed[0] = 1'b1;
        pulse_log.delete();
        repeat (2) wait_col_sample(0);
        pressed[0] = 1'b0;
        repeat (3) wait_col_sample(0);
        chk("glitch_key_down", 16'(key_down), 16'd0);
        chk("glitch_no_pulse", 16'(pulse_log.size()), 16'd0);
        $display("glitch key0: key_down=%h pulses=%0d", key_down, pulse_log.size());
    endtask

    task automatic test_back_to_back();
        wait_col_sample(1);
        pressed = 9'h082;
        pulse_log.delete();
        repeat (2) wait_col_sample(1);
        chk("sim_before_flip", 16'(key_down), 16'd0);
        wait_col_sample(1);
        chk("sim_flip_together", 16'(key_down), 16'h082);
        tick();
        chk("sim_pulse_first", 16'(one_pulse_pos), 16'd1);
        tick();
        chk("sim_pulse_second", 16'(one_pulse_pos), 16'd7);
        tick();
        chk("sim_pulse_idle", 16'(one_pulse_pos), 16'd15);
        pressed = '0;
        repeat (3) wait_col_sample(1);
        chk("sim_released", 16'(key_down), 16'd0);
        chk("sim_pulse_count", 16'(pulse_log.size()), 16'd2);
        $display("simultaneous keys 1,7: pulses seen=%0d", pulse_log.size());
    endtask

    task automatic test_reset_mid_debounce();
        wait_col_sample(1);
        pressed[4] = 1'b1;
        repeat (2) wait_col_sample(1);
        chk("mid_not_set", 16'(key_down[4]), 16'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        pulse_log.delete();
        chk("mid_reset_pulse", 16'(one_pulse_pos), 16'd15);
        chk("mid_reset_col", 16'(col_n), 16'(3'b110));
        repeat (2) wait_col_sample(1);
        chk("mid_needs_three", 16'(key_down[4]), 16'd0);
        wait_col_sample(1);
        chk("mid_set", 16'(key_down[4]), 16'd1);
        tick();
        chk("mid_pulse4", 16'(one_pulse_pos), 16'd4);
        pressed[4] = 1'b0;
        repeat (3) wait_col_sample(1);
        chk("mid_single_pulse", 16'(pulse_log.size()), 16'd1);
        $display("reset mid-debounce key4: pulses seen=%0d", pulse_log.size());
    endtask

    task automatic test_reset_pending();
        int saw3;
        wait_col_sample(0);
        pressed = 9'h009;
        pulse_log.delete();
        repeat (3) wait_col_sample(0);
        chk("pend_flip", 16'(key_down), 16'h009);
        rst     = 1'b1;
        pressed = '0;
        tick();
        rst = 1'b0;
        chk("pend_reset_pulse", 16'(one_pulse_pos), 16'd15);
        chk("pend_reset_keys", 16'(key_down), 16'd0);
        repeat (12) tick();
        saw3 = 0;
        foreach (pulse_log[i]) if (pulse_log[i] == 3) saw3++;
        chk("pend_no_pulse3", 16'(saw3), 16'd0);
        chk("pend_idle_after", 16'(one_pulse_pos), 16'd15);
        $display("reset with pending keys 0,3: pulses seen=%0d", pulse_log.size());
    endtask

    initial begin
        rst     = 1'b1;
        pressed = '0;
        test_reset();
        test_hold_key5();
        test_glitch();
        test_back_to_back();
        test_reset_mid_debounce();
        test_reset_pending();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
